// File: rtl/toggle_monitor.sv
// Half-period monitor for the count7 toggle divider: measures each toggle interval,
// qualifies it against EXP_HALF +/- TOL, declares lock and requests a divider resync on loss.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | monitor disabled, waiting for enable
// ACQUIRE | waiting for the first toggle edge to start interval timing
// TRACK   | measuring intervals, counting consecutive good ones
// LOCKED  | LOCK_N good intervals seen, lock asserted
// RESYNC  | resync pulse to the divider for RESYNC_LEN cycles
module toggle_monitor #(
  parameter int EXP_HALF   = 8,
  parameter int TOL        = 1,
  parameter int LOCK_N     = 4,
  parameter int RESYNC_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             toggle_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             lock,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             resync
);

  localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
  localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(EXP_HALF + TOL + 1);
  localparam logic [7:0]       LOCK_M1 = 8'(LOCK_N - 1);
  localparam logic [7:0]       RS_LOAD = 8'(RESYNC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQUIRE,
    S_TRACK,
    S_LOCKED,
    S_RESYNC
  } state_t;

  state_t           state;
  logic             toggle_d;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       good_cnt;
  logic [7:0]       rs_cnt;

  logic             tog_edge;
  logic             good;
  logic             timeout;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       err_inc;

  always_comb begin
    tog_edge = toggle_in ^ toggle_d;
    good     = (cnt >= LO_LIM) && (cnt <= HI_LIM);
    // an edge landing exactly on the timeout count is judged as a bad interval instead
    timeout  = (cnt == TMO_LIM) && !tog_edge;
    cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      toggle_d    <= 1'b0;
      cnt         <= '0;
      good_cnt    <= '0;
      rs_cnt      <= '0;
      edge_pulse  <= 1'b0;
      half_period <= '0;
      lock        <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      resync      <= 1'b0;
    end else begin
      // tracked in every state so that enabling never sees a stale edge
      toggle_d   <= toggle_in;
      edge_pulse <= 1'b0;
      err_pulse  <= 1'b0;

      if (!enable) begin
        state    <= S_IDLE;
        lock     <= 1'b0;
        resync   <= 1'b0;
        cnt      <= '0;
        good_cnt <= '0;
        rs_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt   <= '0;
            state <= S_ACQUIRE;
          end

          S_ACQUIRE: begin
            if (tog_edge) begin
              cnt      <= CNT_W'(1);
              good_cnt <= '0;
              state    <= S_TRACK;
            end else begin
              cnt <= cnt_inc;
            end
          end

          S_TRACK: begin
            cnt <= tog_edge ? CNT_W'(1) : cnt_inc;
            if (tog_edge) begin
              edge_pulse  <= 1'b1;
              half_period <= cnt;
              if (good) begin
                good_cnt <= good_cnt + 8'd1;
                if (good_cnt == LOCK_M1) begin
                  lock  <= 1'b1;
                  state <= S_LOCKED;
                end
              end else begin
                err_pulse <= 1'b1;
                err_count <= err_inc;
                good_cnt  <= '0;
              end
            end else if (timeout) begin
              err_pulse <= 1'b1;
              err_count <= err_inc;
              good_cnt  <= '0;
              state     <= S_ACQUIRE;
            end
          end

          S_LOCKED: begin
            cnt <= tog_edge ? CNT_W'(1) : cnt_inc;
            if (tog_edge) begin
              edge_pulse  <= 1'b1;
              half_period <= cnt;
            end
            if ((tog_edge && !good) || timeout) begin
              err_pulse <= 1'b1;
              err_count <= err_inc;
              lock      <= 1'b0;
              resync    <= 1'b1;
              rs_cnt    <= RS_LOAD;
              good_cnt  <= '0;
              cnt       <= '0;
              state     <= S_RESYNC;
            end
          end

          S_RESYNC: begin
            cnt <= '0;
            if (rs_cnt == 8'd0) begin
              resync <= 1'b0;
              state  <= S_ACQUIRE;
            end else begin
              rs_cnt <= rs_cnt - 8'd1;
            end
          end

          default: begin
            lock   <= 1'b0;
            resync <= 1'b0;
            cnt    <= '0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor: lock-up, loss of lock, timeout, tolerance edges,
// enable/reset interaction and error counter saturation.
module tb_toggle_monitor;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             toggle_in = 1'b0;
  logic             edge_pulse;
  logic [CNT_W-1:0] half_period;
  logic             lock;
  logic             err_pulse;
  logic [7:0]       err_count;
  logic             resync;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int overlap  = 0;

  toggle_monitor #(
    .EXP_HALF  (8),
    .TOL       (1),
    .LOCK_N    (4),
    .RESYNC_LEN(2),
    .CNT_W     (CNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .toggle_in  (toggle_in),
    .edge_pulse (edge_pulse),
    .half_period(half_period),
    .lock       (lock),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .resync     (resync)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err_pulse) err_seen++;
    if (lock && resync) overlap++;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // edge lands on the n-th clock from now, so back-to-back calls give intervals of n
  task automatic edge_after(input int n);
    repeat (n - 1) tick();
    toggle_in = ~toggle_in;
    tick();
  endtask

  int base;
  int first_err;
  int rs_hi;
  int errs;

  initial begin
    // reset state
    reset_n = 1'b0;
    enable  = 1'b0;
    tick();
    tick();
    check("rst_edge_pulse", edge_pulse, 0);
    check("rst_half_period", half_period, 0);
    check("rst_lock", lock, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_resync", resync, 0);

    // 1. lock-up with intervals of 8
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();
    base = err_seen;
    edge_after(8);
    check("t1_acq_edge_no_pulse", edge_pulse, 0);
    for (int i = 2; i <= 5; i++) begin
      edge_after(8);
      check("t1_edge_pulse", edge_pulse, 1);
      check("t1_half_period", half_period, 8);
      check("t1_lock", lock, (i == 5) ? 1 : 0);
    end
    check("t1_no_errors", err_seen - base, 0);
    check("t1_err_count", err_count, 0);

    // 2. bad interval of 6 while locked
    edge_after(6);
    check("t2_edge_pulse", edge_pulse, 1);
    check("t2_half_period", half_period, 6);
    check("t2_err_pulse", err_pulse, 1);
    check("t2_lock_drop", lock, 0);
    check("t2_resync_on", resync, 1);
    check("t2_err_count", err_count, 1);
    rs_hi = 1;
    errs  = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      rs_hi += resync;
      errs  += err_pulse;
    end
    check("t2_resync_len", rs_hi, 2);
    check("t2_single_err", errs, 0);
    edge_after(3);
    check("t2_reacq_no_pulse", edge_pulse, 0);
    for (int i = 2; i <= 5; i++) begin
      edge_after(8);
      check("t2_relock", lock, (i == 5) ? 1 : 0);
    end
    check("t2_err_count_hold", err_count, 1);

    // 3. timeout while locked: toggle stops
    first_err = -1;
    rs_hi = 0;
    errs  = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (err_pulse && first_err < 0) first_err = k;
      errs  += err_pulse;
      rs_hi += resync;
    end
    check("t3_timeout_cycle", first_err, 10);
    check("t3_single_err", errs, 1);
    check("t3_resync_len", rs_hi, 2);
    check("t3_lock", lock, 0);
    check("t3_err_count", err_count, 2);
    base = err_seen;
    repeat (300) tick();
    check("t3_acquire_quiet", err_seen - base, 0);
    check("t3_err_count_hold", err_count, 2);

    // 4a. tolerance limits 9,7,9,7 in TRACK
    base = err_seen;
    edge_after(5);
    check("t4_acq_edge_no_pulse", edge_pulse, 0);
    edge_after(9);
    check("t4_hp9", half_period, 9);
    edge_after(7);
    check("t4_hp7", half_period, 7);
    edge_after(9);
    check("t4_lock_3rd", lock, 0);
    edge_after(7);
    check("t4_lock_4th", lock, 1);
    check("t4_no_errors", err_seen - base, 0);

    // 4b. 8, 8, 10, then 8 x4
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    base = err_seen;
    edge_after(4);
    edge_after(8);
    edge_after(8);
    check("t4b_lock_pre", lock, 0);
    edge_after(10);
    check("t4b_hp10", half_period, 10);
    check("t4b_err_pulse", err_pulse, 1);
    check("t4b_no_resync", resync, 0);
    check("t4b_err_count", err_count, 3);
    for (int i = 1; i <= 4; i++) begin
      edge_after(8);
      check("t4b_lock", lock, (i == 4) ? 1 : 0);
      check("t4b_no_resync_trk", resync, 0);
    end
    check("t4b_one_err", err_seen - base, 1);

    // 5. enable=0 while locked, re-enable with toggle_in high
    enable = 1'b0;
    tick();
    check("t5_lock_off", lock, 0);
    check("t5_hp_kept", half_period, 8);
    check("t5_errcnt_kept", err_count, 3);
    if (toggle_in == 1'b0) toggle_in = 1'b1;
    tick();
    tick();
    check("t5_no_pulse_idle", edge_pulse, 0);
    check("t5_hp_kept2", half_period, 8);
    enable = 1'b1;
    tick();
    tick();
    tick();
    edge_after(8);
    check("t5_no_spurious_edge", edge_pulse, 0);
    for (int i = 1; i <= 4; i++) begin
      edge_after(8);
      check("t5_relock", lock, (i == 4) ? 1 : 0);
    end

    // 6. reset during RESYNC
    edge_after(6);
    check("t6_resync_on", resync, 1);
    reset_n = 1'b0;
    tick();
    check("t6_resync", resync, 0);
    check("t6_lock", lock, 0);
    check("t6_err_count", err_count, 0);
    check("t6_half_period", half_period, 0);
    check("t6_edge_pulse", edge_pulse, 0);
    check("t6_err_pulse", err_pulse, 0);
    reset_n = 1'b1;
    tick();
    tick();

    // 6b. 300 bad intervals of 5 in TRACK: counter saturates
    edge_after(5);
    for (int i = 1; i <= 300; i++) begin
      edge_after(5);
      if (i == 1) check("t6b_cnt_1", err_count, 1);
      if (i == 254) check("t6b_cnt_254", err_count, 254);
      if (i == 255) check("t6b_cnt_255", err_count, 255);
      if (i == 300) begin
        check("t6b_cnt_sat", err_count, 255);
        check("t6b_err_pulse_sat", err_pulse, 1);
        check("t6b_hp5", half_period, 5);
        check("t6b_no_lock", lock, 0);
      end
    end

    tick();
    check("lock_resync_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
